// File: rtl/bwt_occ_req_issue.sv
// rtl/bwt_occ_req_issue.sv - occurrence-line request FIFO and k/l read serialiser
// Buffers addr_k/addr_l pairs and issues one memory line read per distinct address.
module bwt_occ_req_issue #(
    parameter int ADDR_W       = 42,
    parameter int TAG_W        = 9,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_addr_k,
    input  logic [ADDR_W-1:0]          in_addr_l,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       stall_out,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [TAG_W:0]             mem_req_tag,
    output logic                       mem_req_same,
    output logic                       overflow_err,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {IDLE, SEND_K, SEND_L} state_t;

    logic [ADDR_W-1:0] fifo_k_q   [DEPTH];
    logic [ADDR_W-1:0] fifo_l_q   [DEPTH];
    logic [TAG_W-1:0]  fifo_tag_q [DEPTH];
    logic              fifo_same_q[DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W:0]    tag_q, tag_d;
    logic              same_q, same_d;
    logic [ADDR_W-1:0] cur_l_q, cur_l_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;

    logic full, empty, push, pop, take, accept;

    assign full   = (count_q == FULL_LVL);
    assign empty  = (count_q == '0);
    assign push   = in_valid & ~full;
    assign accept = valid_q & mem_req_ready;

    // Payload storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_k_q[wr_q]    <= in_addr_k;
            fifo_l_q[wr_q]    <= in_addr_l;
            fifo_tag_q[wr_q]  <= in_tag;
            fifo_same_q[wr_q] <= (in_addr_k == in_addr_l);
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        same_d    = same_q;
        cur_l_d   = cur_l_q;
        cur_tag_d = cur_tag_q;
        take      = 1'b0;
        pop       = 1'b0;

        case (state_q)
            IDLE:    take = 1'b1;
            SEND_K: begin
                if (accept) begin
                    if (same_q) begin
                        take = 1'b1;
                    end else begin
                        addr_d  = cur_l_q;
                        tag_d   = {cur_tag_q, 1'b1};
                        same_d  = 1'b0;
                        state_d = SEND_L;
                    end
                end
            end
            SEND_L:  take = accept;
            default: state_d = IDLE;
        endcase

        // "take" means the output register is free for the next head entry.
        pop = take & ~empty;
        if (take) begin
            if (!empty) begin
                valid_d   = 1'b1;
                addr_d    = fifo_k_q[rd_q];
                tag_d     = {fifo_tag_q[rd_q], 1'b0};
                same_d    = fifo_same_q[rd_q];
                cur_l_d   = fifo_l_q[rd_q];
                cur_tag_d = fifo_tag_q[rd_q];
                state_d   = SEND_K;
            end else begin
                valid_d   = 1'b0;
                same_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end

    always_comb begin
        rd_d       = rd_q + PTR_W'(pop);
        wr_d       = wr_q + PTR_W'(push);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        stall_d    = (count_d >= AFULL_LVL);
        overflow_d = overflow_q | (in_valid & full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            tag_q      <= '0;
            same_q     <= 1'b0;
            cur_l_q    <= '0;
            cur_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            same_q     <= same_d;
            cur_l_q    <= cur_l_d;
            cur_tag_q  <= cur_tag_d;
        end
    end

    assign stall_out     = stall_q;
    assign overflow_err  = overflow_q;
    assign mem_req_valid = valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_tag   = tag_q;
    assign mem_req_same  = same_q;
    assign fifo_count    = count_q;

endmodule
